// File: rtl/usb_txn_if.sv
// usb_txn_if: transaction request, encoder and decoder handshake signals of the USB transaction sequencer
interface usb_txn_if;
  logic       txn_start;
  logic       txn_is_in;
  logic       tx_start;
  logic [1:0] tx_kind;
  logic       tx_done;
  logic       rec_start;
  logic       ACK_rec;
  logic       NAK_rec;
  logic       DATA0_rec;
  logic       rec_failed;
  logic       rx_eop;
  logic       rx_data_ok;
  logic       busy;
  logic [3:0] try_cnt;
  logic       txn_done;
  logic       txn_ok;
  modport master (
    output txn_start, txn_is_in, tx_done, ACK_rec, NAK_rec, DATA0_rec, rec_failed, rx_eop, rx_data_ok,
    input  tx_start, tx_kind, rec_start, busy, try_cnt, txn_done, txn_ok
  );
  modport slave (
    input  txn_start, txn_is_in, tx_done, ACK_rec, NAK_rec, DATA0_rec, rec_failed, rx_eop, rx_data_ok,
    output tx_start, tx_kind, rec_start, busy, try_cnt, txn_done, txn_ok
  );
endinterface

// File: rtl/usb_txn_seq.sv
// usb_txn_seq: sequences one USB IN/OUT transaction (token, PID wait, EOP, handshake) with timeout and retries
module usb_txn_seq #(
  parameter int TIMEOUT = 255,
  parameter int MAX_TRY = 8
) (
  input logic       clock,
  input logic       reset_n,
  usb_txn_if.slave  bus
);
  typedef enum logic [3:0] {IDLE, SEND, WAIT_TX, ARM, WAIT_PID, WAIT_EOP, SEND_HS, WAIT_HS, RETRY, DONE} state_t;
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] TRY_LAST = 4'(MAX_TRY);
  state_t     state_q, state_d;
  logic       is_in_q, is_in_d;
  logic       nak_q, nak_d;
  logic       ok_q, ok_d;
  logic [3:0] try_q, try_d;
  logic [7:0] timer_q, timer_d;
  logic       timeout, pid_any, pid_good;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      is_in_q <= 1'b0;
      nak_q   <= 1'b0;
      ok_q    <= 1'b0;
      try_q   <= 4'd0;
      timer_q <= 8'd0;
    end else begin
      state_q <= state_d;
      is_in_q <= is_in_d;
      nak_q   <= nak_d;
      ok_q    <= ok_d;
      try_q   <= try_d;
      timer_q <= timer_d;
    end
  always_comb begin
    state_d  = state_q;
    is_in_d  = is_in_q;
    nak_d    = nak_q;
    ok_d     = ok_q;
    try_d    = try_q;
    timeout  = timer_q == TO_LAST;
    pid_any  = bus.rec_failed | bus.NAK_rec | bus.ACK_rec | bus.DATA0_rec;
    // a pulse of higher priority than the expected PID turns the attempt into a failure
    pid_good = is_in_q ? bus.DATA0_rec & ~bus.ACK_rec & ~bus.NAK_rec & ~bus.rec_failed
                       : bus.ACK_rec & ~bus.NAK_rec & ~bus.rec_failed;
    case (state_q)
      IDLE:     if (bus.txn_start) begin
                  state_d = SEND;
                  is_in_d = bus.txn_is_in;
                  try_d   = 4'd0;
                  ok_d    = 1'b0;
                end
      SEND:     state_d = WAIT_TX;
      WAIT_TX:  state_d = bus.tx_done ? ARM : WAIT_TX;
      ARM:      state_d = WAIT_PID;
      WAIT_PID: state_d = pid_good ? WAIT_EOP : (pid_any || timeout) ? RETRY : WAIT_PID;
      WAIT_EOP: if (bus.rx_eop) begin
                  state_d = is_in_q ? SEND_HS : DONE;
                  nak_d   = is_in_q & ~bus.rx_data_ok;
                  ok_d    = ~is_in_q;
                end else if (timeout) state_d = RETRY;
      SEND_HS:  state_d = WAIT_HS;
      WAIT_HS:  if (bus.tx_done) begin
                  state_d = nak_q ? RETRY : DONE;
                  ok_d    = ~nak_q;
                end
      RETRY:    begin
                  try_d   = try_q + 4'd1;
                  state_d = (try_d == TRY_LAST) ? DONE : SEND;
                end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // the timer restarts from zero on every entry into a waiting state
    timer_d = (state_d == state_q && (state_q == WAIT_PID || state_q == WAIT_EOP)) ? timer_q + 8'd1 : 8'd0;
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.tx_start  = state_q == SEND || state_q == SEND_HS;
  assign bus.tx_kind   = state_q == SEND ? {1'b0, is_in_q} : state_q == SEND_HS ? {1'b1, nak_q} : 2'b00;
  assign bus.rec_start = state_q == ARM;
  assign bus.txn_done  = state_q == DONE;
  assign bus.txn_ok    = state_q == DONE && ok_q;
  assign bus.try_cnt   = try_q;
endmodule

// File: doc/usb_txn_seq.md
USB_TXN_SEQ -- requirements
Module: usb_txn_seq

Parameters
REQ-001 SHALL provide parameter TIMEOUT, default 255, meaning the maximum number of clocks to wait for a receiver PID or EOP event.
REQ-002 SHALL provide parameter MAX_TRY, default 8, meaning the total number of attempts per transaction (range 1..15).

Interface
REQ-003 clock  in  1  system clock, rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 txn_start  in  1  request a new transaction; 1-cycle pulse.
REQ-006 txn_is_in  in  1  transaction type, sampled with txn_start: 1 = IN, 0 = OUT.
REQ-007 tx_start  out  1  1-cycle pulse commanding the encoder to send a packet.
REQ-008 tx_kind  out  2  packet kind, valid with tx_start: 00 = OUT token plus DATA0, 01 = IN token, 10 = ACK, 11 = NAK.
REQ-009 tx_done  in  1  1-cycle pulse from the encoder when the packet, including EOP, is on the wire.
REQ-010 rec_start  out  1  1-cycle pulse arming the DP/DM decoder.
REQ-011 ACK_rec, NAK_rec, DATA0_rec, rec_failed  in  1 each  decoder PID-result pulses.
REQ-012 rx_eop  in  1  1-cycle pulse when the decoder finishes EOP and returns to idle.
REQ-013 rx_data_ok  in  1  DATA0 CRC good; sampled only in the rx_eop cycle.
REQ-014 busy  out  1  high whenever the state is not IDLE.
REQ-015 try_cnt  out  4  number of failed attempts in the current transaction.
REQ-016 txn_done  out  1  1-cycle completion pulse.
REQ-017 txn_ok  out  1  transaction result, valid only in the txn_done cycle.

Function
REQ-018 SHALL use the states IDLE, SEND, WAIT_TX, ARM, WAIT_PID, WAIT_EOP, SEND_HS, WAIT_HS, RETRY and DONE.
REQ-019 In IDLE, txn_start SHALL latch txn_is_in, clear try_cnt, and move to SEND; tx_start SHALL pulse in the next cycle.
REQ-020 SEND SHALL assert tx_start for one cycle (tx_kind 00 for OUT, 01 for IN) and then move to WAIT_TX.
REQ-021 WAIT_TX SHALL hold until tx_done, then move to ARM; there is no timeout in WAIT_TX.
REQ-022 ARM SHALL pulse rec_start for one cycle, clear the timer, and move to WAIT_PID.
REQ-023 Timer rules: 8-bit counter, increments every clock in WAIT_PID and WAIT_EOP, cleared on entry to each of those states; the timeout fires when the count equals TIMEOUT-1.
REQ-024 WAIT_PID for an OUT transaction: ACK_rec -> WAIT_EOP with pass flag set; NAK_rec, DATA0_rec, rec_failed or timeout -> RETRY.
REQ-025 WAIT_PID for an IN transaction: DATA0_rec -> WAIT_EOP; NAK_rec, ACK_rec, rec_failed or timeout -> RETRY.
REQ-026 If a PID pulse and the timeout occur in the same cycle, the PID SHALL win.
REQ-027 If several PID pulses occur in the same cycle, the priority SHALL be rec_failed > NAK > ACK > DATA0.
REQ-028 WAIT_EOP for an OUT transaction: rx_eop -> DONE with txn_ok=1; timeout -> RETRY.
REQ-029 WAIT_EOP for an IN transaction: rx_eop with rx_data_ok=1 -> SEND_HS(ACK); rx_eop with rx_data_ok=0 -> SEND_HS(NAK) then RETRY; timeout -> RETRY.
REQ-030 SEND_HS SHALL pulse tx_start with tx_kind 10 or 11 and move to WAIT_HS; WAIT_HS SHALL wait for tx_done, then go to DONE (ACK sent) or RETRY (NAK sent).
REQ-031 RETRY SHALL take one cycle and increment try_cnt; if the new value equals MAX_TRY it SHALL go to DONE with txn_ok=0, otherwise to SEND.
REQ-032 DONE SHALL pulse txn_done with txn_ok for one cycle, then return to IDLE.
REQ-033 try_cnt SHALL keep its value after DONE until the next accepted txn_start.
REQ-034 txn_start while busy SHALL be ignored and not queued.
REQ-035 Decoder pulses outside WAIT_PID or WAIT_EOP SHALL be ignored.
REQ-036 tx_done outside WAIT_TX or WAIT_HS SHALL be ignored.
REQ-037 tx_start and rec_start SHALL never be asserted in the same cycle.
REQ-038 All outputs except try_cnt SHALL be pure functions of the state; try_cnt comes from its own register.

Reset
REQ-039 reset_n low SHALL immediately force IDLE, and set busy, tx_start, rec_start, txn_done and txn_ok to 0, tx_kind to 00, try_cnt to 0, and the timer to 0.
REQ-040 Reset mid-transaction SHALL abort the transaction with no txn_done pulse; the first txn_start after release SHALL be accepted normally.

Verification
REQ-041 OUT success: txn_start with txn_is_in=0, tx_done, ACK_rec 5 clocks later, rx_eop -> one tx_start (kind 00), one rec_start, txn_done with txn_ok=1, try_cnt=0.
REQ-042 IN success: txn_is_in=1, DATA0_rec, rx_eop with rx_data_ok=1 -> tx_start kind 01, then tx_start kind 10, then txn_done with txn_ok=1.
REQ-043 IN CRC error then success: first rx_data_ok=0 -> NAK sent, try_cnt=1, IN token resent; second attempt good -> txn_ok=1, try_cnt=1.
REQ-044 Silent device: no decoder pulses -> rec_start, then 255 clocks later RETRY, repeated 8 times -> txn_done with txn_ok=0, try_cnt=8.
REQ-045 Collision: ACK_rec in the same cycle the timer reaches 254 -> accepted, no retry; txn_start pulsed while busy -> no effect.
REQ-046 Reset asserted in WAIT_PID -> outputs zero within the same cycle; a new OUT transaction after release completes normally.
